// File: rtl/aurora_rx_merge.sv
// Merges the two Aurora receive streams into one 64-bit router stream.
// Each input has its own FIFO; a round-robin arbiter switches ports only between packets.
module aurora_rx_merge #(
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 4
) (
  input  logic        CLK250,
  input  logic        SYS_RST,
  input  logic [63:0] DP0_Q,
  input  logic        DP0_Q_VALID,
  output logic        DP0_Q_BP,
  input  logic [63:0] DP1_Q,
  input  logic        DP1_Q_VALID,
  output logic        DP1_Q_BP,
  output logic [63:0] M_D,
  output logic        M_D_VALID,
  input  logic        M_D_BP,
  output logic [1:0]  OVF
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(FIFO_DEPTH - AF_MARGIN);

  typedef enum logic {IDLE, BODY} state_t;

  state_t        state, state_nx;
  logic          last, last_nx;
  logic [7:0]    rem, rem_nx;
  logic          rd_en, rd_port;
  logic [63:0]   rd_data;

  logic [63:0]   q_in [2];
  logic [1:0]    q_valid;
  logic [63:0]   mem [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [CW-1:0] count [2];
  logic [CW-1:0] count_nx [2];
  logic [1:0]    empty, full, wr_en, rd_sel, bp;

  assign q_in[0]  = DP0_Q;
  assign q_in[1]  = DP1_Q;
  assign q_valid  = {DP1_Q_VALID, DP0_Q_VALID};
  assign DP0_Q_BP = bp[0];
  assign DP1_Q_BP = bp[1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = (count[i] == '0);
      full[i]  = (count[i] == FULL_LVL);
    end
  end

  // A full FIFO still accepts a flit when the same cycle reads from it.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rd_sel[i]   = rd_en && (rd_port == 1'(i));
      wr_en[i]    = q_valid[i] && (!full[i] || rd_sel[i]);
      count_nx[i] = count[i] + CW'(wr_en[i]) - CW'(rd_sel[i]);
    end
  end

  // Grant: in IDLE prefer the port that did not send last; in BODY stay put.
  always_comb begin
    rd_port = last;
    if (state == IDLE) begin
      if (empty == 2'b00)
        rd_port = ~last;
      else if (!empty[0])
        rd_port = 1'b0;
      else
        rd_port = 1'b1;
    end
  end

  assign rd_data = mem[rd_port][rd_ptr[rd_port]];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    last_nx  = last;
    rem_nx   = rem;
    rd_en    = 1'b0;
    case (state)
      IDLE: begin
        if (empty != 2'b11 && !M_D_BP) begin
          rd_en   = 1'b1;
          last_nx = rd_port;
          rem_nx  = rd_data[7:0];
          if (rd_data[7:0] != 8'd0)
            state_nx = BODY;
        end
      end
      BODY: begin
        if (!empty[rd_port] && !M_D_BP) begin
          rd_en  = 1'b1;
          rem_nx = (rem != 8'd0) ? rem - 8'd1 : 8'd0;
          if (rem == 8'd1)
            state_nx = IDLE;
        end
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK250) begin
    if (SYS_RST) begin
      state <= IDLE;
      last  <= 1'b1;
      rem   <= 8'd0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      rem   <= rem_nx;
    end
  end

  always_ff @(posedge CLK250) begin
    if (SYS_RST) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      bp  <= 2'b00;
      OVF <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i])
          wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (rd_sel[i])
          rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i] <= count_nx[i];
        bp[i]    <= (count_nx[i] >= AF_LVL);
        if (q_valid[i] && !wr_en[i])
          OVF[i] <= 1'b1;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and counts alone define which entries are valid.
  always_ff @(posedge CLK250) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i])
        mem[i][wr_ptr[i]] <= q_in[i];
    end
  end

  always_ff @(posedge CLK250) begin
    if (SYS_RST) begin
      M_D_VALID <= 1'b0;
      M_D       <= 64'd0;
    end else begin
      M_D_VALID <= rd_en;
      if (rd_en)
        M_D <= rd_data;
    end
  end

endmodule
